// File: rtl/usb_tx_packet.sv
// usb_tx_packet: turns a handshake or data request from the control-endpoint
// setup stage into a USB packet byte stream (PID, payload, CRC16).
// Payload bytes are pulled from the send queue one read per byte.
// SYNC, EOP, NRZI and bit-stuffing are added downstream by the serializer.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for send_hs / send_data
// HS_PID   | presenting the handshake PID (single-byte packet)
// DATA_PID | presenting DATA0/DATA1 PID, CRC re-initialised
// FETCH    | one-cycle queue read strobe
// WAIT     | queue data valid; captured into tx_data and folded into CRC
// PAYLOAD  | payload byte pending until accepted by the serializer
// CRC_LO   | presenting low byte of ~crc
// CRC_HI   | presenting high byte of ~crc, marked as last byte

module usb_tx_packet #(
  parameter int MAX_PAYLOAD = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send_hs,
  input  logic [1:0] handshake,
  input  logic       send_data,
  input  logic       data_toggle,
  output logic       usb_send_queue_r_en,
  input  logic [7:0] usb_send_queue_data_out,
  input  logic       usb_send_queue_empty,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       tx_last,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic [7:0] byte_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HS_PID,
    S_DATA_PID,
    S_FETCH,
    S_WAIT,
    S_PAYLOAD,
    S_CRC_LO,
    S_CRC_HI
  } state_t;

  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;

  // 9 bits so the post-increment count never wraps before the compare.
  localparam logic [8:0] LP_MAX = 9'(MAX_PAYLOAD);

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_pid;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;
  logic        r_tx_last;
  logic        r_rd_en;
  logic        r_done;
  logic [7:0]  r_byte_count;
  logic [7:0]  r_cnt;
  logic [15:0] r_crc;

  logic        w_accept;
  logic [8:0]  w_cnt_inc;

  // Reflected CRC16 (poly 0xA001), one byte, LSB first.
  function automatic logic [15:0] f_crc16(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 16'hA001;
      else             c = c >> 1;
    end
    return c;
  endfunction

  function automatic logic [7:0] f_hs_pid(input logic [1:0] code);
    logic [7:0] p;
    case (code)
      2'b10:   p = PID_NAK;
      2'b11:   p = PID_STALL;
      default: p = PID_ACK;
    endcase
    return p;
  endfunction

  assign w_accept  = r_tx_valid & tx_ready;
  assign w_cnt_inc = {1'b0, r_cnt} + 9'd1;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state decode; every byte state advances only on a serializer accept.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (send_hs) begin
          if (handshake != 2'b01) w_state_next = S_HS_PID;
        end else if (send_data) begin
          w_state_next = S_DATA_PID;
        end
      end
      S_HS_PID: begin
        if (w_accept) w_state_next = S_IDLE;
      end
      S_DATA_PID: begin
        if (w_accept) begin
          if (usb_send_queue_empty || (LP_MAX == 9'd0)) w_state_next = S_CRC_LO;
          else                                          w_state_next = S_FETCH;
        end
      end
      S_FETCH: w_state_next = S_WAIT;
      S_WAIT:  w_state_next = S_PAYLOAD;
      S_PAYLOAD: begin
        if (w_accept) begin
          if ((w_cnt_inc < LP_MAX) && !usb_send_queue_empty) w_state_next = S_FETCH;
          else                                               w_state_next = S_CRC_LO;
        end
      end
      S_CRC_LO: begin
        if (w_accept) w_state_next = S_CRC_HI;
      end
      S_CRC_HI: begin
        if (w_accept) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output byte register, CRC, counters and strobes. A byte is loaded the
  // cycle after its state is entered and held untouched until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pid        <= 8'h00;
      r_tx_data    <= 8'h00;
      r_tx_valid   <= 1'b0;
      r_tx_last    <= 1'b0;
      r_rd_en      <= 1'b0;
      r_done       <= 1'b0;
      r_byte_count <= 8'h00;
      r_cnt        <= 8'h00;
      r_crc        <= 16'hFFFF;
    end else begin
      r_done  <= 1'b0;
      r_rd_en <= (w_state_next == S_FETCH);
      case (r_state)
        S_IDLE: begin
          if (send_hs) begin
            r_pid <= f_hs_pid(handshake);
            if (handshake == 2'b01) r_done <= 1'b1;
          end else if (send_data) begin
            r_pid <= data_toggle ? PID_DATA1 : PID_DATA0;
            r_cnt <= 8'h00;
          end
        end
        S_HS_PID: begin
          if (!r_tx_valid) begin
            r_tx_data  <= r_pid;
            r_tx_valid <= 1'b1;
            r_tx_last  <= 1'b1;
          end else if (w_accept) begin
            r_tx_valid <= 1'b0;
            r_tx_last  <= 1'b0;
            r_done     <= 1'b1;
          end
        end
        S_DATA_PID: begin
          if (!r_tx_valid) begin
            r_tx_data  <= r_pid;
            r_tx_valid <= 1'b1;
            r_tx_last  <= 1'b0;
            r_crc      <= 16'hFFFF;
          end else if (w_accept) begin
            r_tx_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          r_tx_data  <= usb_send_queue_data_out;
          r_tx_valid <= 1'b1;
          r_tx_last  <= 1'b0;
          r_crc      <= f_crc16(r_crc, usb_send_queue_data_out);
        end
        S_PAYLOAD: begin
          if (w_accept) begin
            r_tx_valid <= 1'b0;
            r_cnt      <= w_cnt_inc[7:0];
          end
        end
        S_CRC_LO: begin
          if (!r_tx_valid) begin
            r_tx_data  <= ~r_crc[7:0];
            r_tx_valid <= 1'b1;
            r_tx_last  <= 1'b0;
          end else if (w_accept) begin
            r_tx_valid <= 1'b0;
          end
        end
        S_CRC_HI: begin
          if (!r_tx_valid) begin
            r_tx_data  <= ~r_crc[15:8];
            r_tx_valid <= 1'b1;
            r_tx_last  <= 1'b1;
          end else if (w_accept) begin
            r_tx_valid   <= 1'b0;
            r_tx_last    <= 1'b0;
            r_done       <= 1'b1;
            r_byte_count <= r_cnt;
          end
        end
        default: ;
      endcase
    end
  end

  assign usb_send_queue_r_en = r_rd_en;
  assign tx_data             = r_tx_data;
  assign tx_valid            = r_tx_valid;
  assign tx_last             = r_tx_last;
  assign busy                = (r_state != S_IDLE);
  assign done                = r_done;
  assign byte_count          = r_byte_count;

endmodule

// File: tb/tb_usb_tx_packet.sv
// Bench for usb_tx_packet: two instances (default payload limit and a
// limit of 4) share one queue model; a scoreboard of expected bytes is
// checked against every byte the active instance hands to the serializer.
`timescale 1ns/1ps

module tb_usb_tx_packet;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, send_hs, send_data_a, send_data_b, data_toggle, hs_b;
  logic [1:0] handshake;
  logic       tx_ready;
  logic       sel, rand_mode, ready_fix;

  logic       a_ren, a_valid, a_last, a_busy, a_done;
  logic [7:0] a_data, a_bc;
  logic       b_ren, b_valid, b_last, b_busy, b_done;
  logic [7:0] b_data, b_bc;

  logic [7:0] q_dout = 8'h00;
  logic       q_empty;
  logic [7:0] qmem [0:63];
  int         q_wr = 0, q_rd = 0, ren_cnt = 0, acc_cnt = 0;

  logic [8:0] exp_q[$];
  int n_tests = 0, n_fail = 0;

  usb_tx_packet u_dut_a (
    .clk(clk), .rst(rst), .send_hs(send_hs), .handshake(handshake),
    .send_data(send_data_a), .data_toggle(data_toggle),
    .usb_send_queue_r_en(a_ren), .usb_send_queue_data_out(q_dout),
    .usb_send_queue_empty(q_empty), .tx_data(a_data), .tx_valid(a_valid),
    .tx_last(a_last), .tx_ready(tx_ready), .busy(a_busy), .done(a_done),
    .byte_count(a_bc)
  );

  usb_tx_packet #(.MAX_PAYLOAD(4)) u_dut_b (
    .clk(clk), .rst(rst), .send_hs(hs_b), .handshake(handshake),
    .send_data(send_data_b), .data_toggle(data_toggle),
    .usb_send_queue_r_en(b_ren), .usb_send_queue_data_out(q_dout),
    .usb_send_queue_empty(q_empty), .tx_data(b_data), .tx_valid(b_valid),
    .tx_last(b_last), .tx_ready(tx_ready), .busy(b_busy), .done(b_done),
    .byte_count(b_bc)
  );

  wire       m_valid = sel ? b_valid : a_valid;
  wire       m_last  = sel ? b_last  : a_last;
  wire [7:0] m_data  = sel ? b_data  : a_data;
  wire       m_busy  = sel ? b_busy  : a_busy;
  wire       m_done  = sel ? b_done  : a_done;
  wire       m_ren   = a_ren | b_ren;

  assign q_empty = (q_rd == q_wr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Queue model: a read strobe pops one byte, held on data_out afterwards.
  always @(negedge clk) begin
    if (m_ren) begin
      ren_cnt++;
      if (q_rd < q_wr) begin
        q_dout = qmem[q_rd];
        q_rd++;
      end
    end
  end

  // Serializer ready: fixed or random, changed just after the active edge.
  always @(posedge clk) begin
    #1;
    tx_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_fix;
  end

  // Scoreboard monitor plus stall-stability and read-while-pending checks.
  logic       prev_pend = 1'b0, prev_last = 1'b0;
  logic [7:0] prev_d = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      prev_pend = 1'b0;
    end else begin
      if (prev_pend) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, prev_d);
        chk("stall_last", m_last, prev_last);
      end
      if (m_valid) chk("ren_pending", m_ren, 0);
      if (m_valid && tx_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) chk("sb_underflow", exp_q.size(), 1);
        else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("tx_data", m_data, e[7:0]);
          chk("tx_last", m_last, e[8]);
        end
      end
      prev_pend = m_valid && !tx_ready;
      prev_d    = m_data;
      prev_last = m_last;
    end
  end

  task automatic push_exp(input logic [7:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  task automatic load_q(input logic [7:0] bytes[$]);
    for (int k = 0; k < bytes.size(); k++) begin
      qmem[q_wr] = bytes[k];
      q_wr++;
    end
  endtask

  // Reference CRC: MSB-first USB polynomial on bit-reversed register,
  // reflected at the end; returns the complemented value as transmitted.
  function automatic logic [15:0] ref_crc(input logic [7:0] bytes[$]);
    logic [15:0] c, r;
    logic fb;
    c = 16'hFFFF;
    for (int k = 0; k < bytes.size(); k++)
      for (int i = 0; i < 8; i++) begin
        fb = c[15] ^ bytes[k][i];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    for (int i = 0; i < 16; i++) r[i] = c[15 - i];
    return ~r;
  endfunction

  task automatic req_hs(input logic [1:0] code);
    @(posedge clk); #2;
    send_hs = 1'b1; handshake = code;
    @(posedge clk); #2;
    send_hs = 1'b0;
  endtask

  task automatic req_data(input logic tog, input logic to_b);
    @(posedge clk); #2;
    data_toggle = tog;
    if (to_b) send_data_b = 1'b1; else send_data_a = 1'b1;
    @(posedge clk); #2;
    send_data_a = 1'b0; send_data_b = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_busy, input int budget);
    int  bc;
    logic seen;
    bc = 0; seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (m_done) seen = 1'b1;
      else if (m_busy) bc++;
    end
    chk({tag, "_done_seen"}, seen, 1);
    if (seen) begin
      chk({tag, "_busy_at_done"}, m_busy, 0);
      if (exp_busy >= 0) chk({tag, "_busy_cycles"}, bc, exp_busy);
      @(negedge clk);
      chk({tag, "_done_pulse"}, m_done, 0);
    end
    chk({tag, "_sb_drained"}, exp_q.size(), 0);
  endtask

  logic [7:0] setup_pkt[$];
  logic [7:0] ten[$];
  logic [7:0] first4[$];
  logic [15:0] crc;
  int base_ren, base_acc;
  logic hit;

  initial begin
    rst = 1'b1; send_hs = 1'b0; send_data_a = 1'b0; send_data_b = 1'b0;
    hs_b = 1'b0; data_toggle = 1'b0; handshake = 2'b00;
    sel = 1'b0; rand_mode = 1'b0; ready_fix = 1'b1; tx_ready = 1'b1;
    setup_pkt = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h12, 8'h00};
    ten    = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
    first4 = '{8'h11, 8'h22, 8'h33, 8'h44};

    repeat (3) @(posedge clk);
    #2;
    chk("rst_tx_valid", a_valid, 0);
    chk("rst_tx_last", a_last, 0);
    chk("rst_tx_data", a_data, 0);
    chk("rst_r_en", m_ren, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_byte_count", a_bc, 0);
    rst = 1'b0;

    // handshakes
    push_exp(8'hD2, 1'b1); req_hs(2'b00); wait_done("hs_ack", 2, 20);
    req_hs(2'b01);                        wait_done("hs_none", 0, 20);
    push_exp(8'h1E, 1'b1); req_hs(2'b11); wait_done("hs_stall", 2, 20);
    push_exp(8'h5A, 1'b1); req_hs(2'b10); wait_done("hs_nak", 2, 20);

    // zero-length DATA0
    push_exp(8'hC3, 1'b0); push_exp(8'h00, 1'b0); push_exp(8'h00, 1'b1);
    req_data(1'b0, 1'b0);
    wait_done("zlp", -1, 50);
    chk("zlp_byte_count", a_bc, 0);

    // 8-byte setup payload, DATA1
    load_q(setup_pkt);
    crc = ref_crc(setup_pkt);
    push_exp(8'h4B, 1'b0);
    foreach (setup_pkt[k]) push_exp(setup_pkt[k], 1'b0);
    push_exp(crc[7:0], 1'b0); push_exp(crc[15:8], 1'b1);
    base_ren = ren_cnt;
    req_data(1'b1, 1'b0);
    wait_done("setup8", -1, 300);
    chk("setup8_reads", ren_cnt - base_ren, 8);
    chk("setup8_byte_count", a_bc, 8);
    chk("setup8_queue_left", q_wr - q_rd, 0);

    // payload limit 4, random backpressure
    sel = 1'b1; rand_mode = 1'b1;
    load_q(ten);
    crc = ref_crc(first4);
    push_exp(8'hC3, 1'b0);
    foreach (first4[k]) push_exp(first4[k], 1'b0);
    push_exp(crc[7:0], 1'b0); push_exp(crc[15:8], 1'b1);
    base_ren = ren_cnt;
    req_data(1'b0, 1'b1);
    wait_done("max4", -1, 600);
    chk("max4_reads", ren_cnt - base_ren, 4);
    chk("max4_byte_count", b_bc, 4);
    chk("max4_queue_left", q_wr - q_rd, 6);
    rand_mode = 1'b0;
    q_wr = q_rd;
    @(posedge clk); @(posedge clk);

    // reset while payload byte 3 is pending
    sel = 1'b0;
    load_q(setup_pkt);
    push_exp(8'h4B, 1'b0); push_exp(setup_pkt[0], 1'b0); push_exp(setup_pkt[1], 1'b0);
    base_acc = acc_cnt;
    req_data(1'b1, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (acc_cnt - base_acc >= 3) hit = 1'b1;
    end
    chk("mid_rst_reach_b2", hit, 1);
    ready_fix = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (a_valid) hit = 1'b1;
    end
    chk("mid_rst_b3_pending", hit, 1);
    chk("mid_rst_b3_data", a_data, setup_pkt[2]);
    @(posedge clk); #2; rst = 1'b1;
    @(posedge clk); #2;
    chk("mid_rst_tx_valid", a_valid, 0);
    chk("mid_rst_r_en", m_ren, 0);
    chk("mid_rst_busy", a_busy, 0);
    chk("mid_rst_done", a_done, 0);
    chk("mid_rst_tx_data", a_data, 0);
    @(posedge clk); #2;
    chk("mid_rst_no_done", a_done, 0);
    rst = 1'b0;
    exp_q.delete();
    q_wr = q_rd;
    ready_fix = 1'b1;
    @(posedge clk); @(posedge clk);
    push_exp(8'hD2, 1'b1); req_hs(2'b00); wait_done("post_rst_ack", 2, 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
